// File: rtl/hdmi_timing_selector.sv
// hdmi_timing_selector: one shared raster counter driving cx/cy, syncs and de for up to three CEA timings.
// Latency: every output is registered and decoded from the cx/cy it is presented with (0 cycles relative).
// No backpressure; mode changes land only on a frame boundary. Macro TIMING_MUTE_EN adds post-switch de mute.
module hdmi_timing_selector #(
  parameter int NUM_MODES    = 2,
  parameter int DEFAULT_MODE = 0,
  parameter int MUTE_FRAMES  = 2,
  parameter int MW           = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  // Timing table, entry i lives in slice [i]. Defaults: [0] VIC2 480p, [1] VIC17 576p, [2] VIC1 VGA.
  parameter logic [2:0][10:0] H_TOTAL_T  = {11'd800, 11'd864, 11'd858},
  parameter logic [2:0][10:0] H_ACTIVE_T = {11'd640, 11'd720, 11'd720},
  parameter logic [2:0][10:0] H_FP_T     = {11'd16,  11'd12,  11'd16},
  parameter logic [2:0][10:0] H_SW_T     = {11'd96,  11'd64,  11'd62},
  parameter logic [2:0][9:0]  V_TOTAL_T  = {10'd525, 10'd625, 10'd525},
  parameter logic [2:0][9:0]  V_ACTIVE_T = {10'd480, 10'd576, 10'd480},
  parameter logic [2:0][9:0]  V_FP_T     = {10'd10,  10'd5,   10'd9},
  parameter logic [2:0][9:0]  V_SW_T     = {10'd2,   10'd5,   10'd6}
) (
  input  logic          clk_pixel,
  input  logic          reset,
  input  logic [MW-1:0] mode_req,
  output logic [10:0]   cx,
  output logic [9:0]    cy,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frame_start,
  output logic [MW-1:0] active_mode,
  output logic          switching
);

  // Reject configurations the table and port widths cannot represent.
  if (NUM_MODES < 1 || NUM_MODES > 3 || DEFAULT_MODE < 0 || DEFAULT_MODE >= NUM_MODES ||
      MUTE_FRAMES < 1 || MUTE_FRAMES > 15) begin : g_bad_cfg
    $error("hdmi_timing_selector: parameter out of range");
  end

  localparam logic [MW:0]   NUM_M = NUM_MODES[MW:0];
  localparam logic [MW-1:0] DEF_M = DEFAULT_MODE[MW-1:0];

  typedef enum logic [1:0] {
    IDLE,
    PENDING
`ifdef TIMING_MUTE_EN
    ,
    MUTE
`endif
  } state_t;

  state_t        state;
  logic [MW-1:0] target;
  logic          first;   // set by reset so the first running cycle presents 0,0

`ifdef TIMING_MUTE_EN
  localparam logic [3:0] MUTE_N = MUTE_FRAMES[3:0];
  logic [3:0]    mute_cnt;
`endif

  logic [1:0]    act_i;
  logic [1:0]    nxt_i;
  logic [10:0]   ht_a;
  logic [9:0]    vt_a;
  logic [10:0]   nxt_cx;
  logic [9:0]    nxt_cy;
  logic [10:0]   hs_beg;
  logic [10:0]   hs_end;
  logic [9:0]    vs_beg;
  logic [9:0]    vs_end;
  logic          last_px;
  logic          frame_nxt;
  logic          req_ok;
  logic [MW-1:0] pend_tgt;
  logic          go;
  logic [MW-1:0] mode_nxt;
  logic          mute_nxt;

  // Next raster position, switch decision and the decode window of the mode that owns the next pixel.
  always_comb begin
    act_i   = 2'(active_mode);
    ht_a    = H_TOTAL_T[act_i];
    vt_a    = V_TOTAL_T[act_i];
    last_px = !first && (cx == ht_a - 11'd1) && (cy == vt_a - 10'd1);

    nxt_cx = '0;
    nxt_cy = '0;
    if (!first) begin
      if (cx == ht_a - 11'd1) begin
        nxt_cx = '0;
        nxt_cy = (cy == vt_a - 10'd1) ? 10'd0 : cy + 10'd1;
      end else begin
        nxt_cx = cx + 11'd1;
        nxt_cy = cy;
      end
    end
    frame_nxt = (nxt_cx == 11'd0) && (nxt_cy == 10'd0);

    // A valid request sampled this cycle overrides the latched target, including on the boundary cycle.
    req_ok   = ({1'b0, mode_req} < NUM_M);
    pend_tgt = req_ok ? mode_req : target;
    go       = (state == PENDING) && last_px && (pend_tgt != active_mode);
    mode_nxt = go ? pend_tgt : active_mode;
    nxt_i    = 2'(mode_nxt);

    hs_beg = H_ACTIVE_T[nxt_i] + H_FP_T[nxt_i];
    hs_end = hs_beg + H_SW_T[nxt_i];
    vs_beg = V_ACTIVE_T[nxt_i] + V_FP_T[nxt_i];
    vs_end = vs_beg + V_SW_T[nxt_i];

`ifdef TIMING_MUTE_EN
    // Muted from the switch wrap until the frame_start on which the count expires.
    mute_nxt = go || ((state == MUTE) && !(frame_nxt && (mute_cnt == 4'd1)));
`else
    mute_nxt = 1'b0;
`endif
  end

  // Raster counters and the outputs decoded from the same position.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      first       <= 1'b1;
      cx          <= '0;
      cy          <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      first       <= 1'b0;
      cx          <= nxt_cx;
      cy          <= nxt_cy;
      hsync       <= !((nxt_cx >= hs_beg) && (nxt_cx < hs_end));
      vsync       <= !((nxt_cy >= vs_beg) && (nxt_cy < vs_end));
      de          <= (nxt_cx < H_ACTIVE_T[nxt_i]) && (nxt_cy < V_ACTIVE_T[nxt_i]) && !mute_nxt;
      frame_start <= frame_nxt;
    end
  end

  // Mode-change FSM: latch a request, switch on the last pixel of the frame, optionally mute after.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state       <= IDLE;
      active_mode <= DEF_M;
      target      <= DEF_M;
      switching   <= 1'b0;
`ifdef TIMING_MUTE_EN
      mute_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_ok && (mode_req != active_mode)) begin
            target    <= mode_req;
            state     <= PENDING;
            switching <= 1'b1;
          end
        end
        PENDING: begin
          if (req_ok && (mode_req == active_mode)) begin
            // Request withdrawn before the boundary: no timing change.
            state     <= IDLE;
            switching <= 1'b0;
          end else if (go) begin
            active_mode <= pend_tgt;
            target      <= pend_tgt;
`ifdef TIMING_MUTE_EN
            state       <= MUTE;
            mute_cnt    <= MUTE_N;
`else
            state       <= IDLE;
            switching   <= 1'b0;
`endif
          end else if (req_ok) begin
            target <= mode_req;
          end
        end
`ifdef TIMING_MUTE_EN
        MUTE: begin
          // Requests are ignored here and picked up again once back in IDLE.
          if (frame_nxt) begin
            if (mute_cnt == 4'd1) begin
              state     <= IDLE;
              switching <= 1'b0;
              mute_cnt  <= '0;
            end else begin
              mute_cnt <= mute_cnt - 4'd1;
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_timing_selector.sv
// tb_hdmi_timing_selector: u_a runs the built-in CEA table for its first lines; u_b uses a miniature table
// so whole frames, switches, cancels and reset-while-pending fit in a short run.
// u_b outputs are checked every cycle against the frame expectation queue filled by the stimulus.
`timescale 1ns/1ps
module tb_hdmi_timing_selector;

`ifdef TIMING_MUTE_EN
  localparam int MUTE_N = 2;
`else
  localparam int MUTE_N = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- u_a: default CEA table ----------------
  logic        rst_a = 1'b1;
  logic [0:0]  req_a = 1'b0;
  logic [10:0] a_cx;
  logic [9:0]  a_cy;
  logic        a_hs, a_vs, a_de, a_fs, a_sw;
  logic [0:0]  a_am;

  hdmi_timing_selector u_a (
    .clk_pixel(clk), .reset(rst_a), .mode_req(req_a),
    .cx(a_cx), .cy(a_cy), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .frame_start(a_fs), .active_mode(a_am), .switching(a_sw)
  );

  // ---------------- u_b: miniature table, MW widened to reach out-of-range values ----------------
  logic        rst_b = 1'b1;
  logic [1:0]  req_b = 2'd0;
  logic [10:0] b_cx;
  logic [9:0]  b_cy;
  logic        b_hs, b_vs, b_de, b_fs, b_sw;
  logic [1:0]  b_am;

  hdmi_timing_selector #(
    .NUM_MODES(2), .DEFAULT_MODE(0), .MUTE_FRAMES(2), .MW(2),
    .H_TOTAL_T ({11'd16, 11'd24, 11'd20}),
    .H_ACTIVE_T({11'd8,  11'd14, 11'd12}),
    .H_FP_T    ({11'd2,  11'd3,  11'd2}),
    .H_SW_T    ({11'd2,  11'd4,  11'd3}),
    .V_TOTAL_T ({10'd8,  10'd12, 10'd10}),
    .V_ACTIVE_T({10'd4,  10'd8,  10'd6}),
    .V_FP_T    ({10'd1,  10'd2,  10'd1}),
    .V_SW_T    ({10'd1,  10'd1,  10'd2})
  ) u_b (
    .clk_pixel(clk), .reset(rst_b), .mode_req(req_b),
    .cx(b_cx), .cy(b_cy), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .frame_start(b_fs), .active_mode(b_am), .switching(b_sw)
  );

  int bht[3] = '{20, 24, 16};
  int bha[3] = '{12, 14, 8};
  int bhf[3] = '{2, 3, 2};
  int bhs[3] = '{3, 4, 2};
  int bvt[3] = '{10, 12, 8};
  int bva[3] = '{6, 8, 4};
  int bvf[3] = '{1, 2, 1};
  int bvs[3] = '{2, 1, 1};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic check_rst(input string tag, input int cxv, input int cyv, input int hs, input int vs,
                           input int dev, input int fs, input int am, input int sw);
    check_val({tag, "_cx"}, cxv, 0);
    check_val({tag, "_cy"}, cyv, 0);
    check_val({tag, "_hsync"}, hs, 1);
    check_val({tag, "_vsync"}, vs, 1);
    check_val({tag, "_de"}, dev, 0);
    check_val({tag, "_fs"}, fs, 0);
    check_val({tag, "_mode"}, am, 0);
    check_val({tag, "_switching"}, sw, 0);
  endtask

  // Scoreboard: one entry per expected frame of u_b (its mode and whether de is muted).
  typedef struct { int mode; bit muted; } frame_t;
  frame_t sb[$];
  frame_t cur = '{0, 1'b0};
  int     t_b = 0;       // pixel index inside the current frame
  int     k_b = 0;       // output cycles checked since reset release
  bit     need_pop = 1'b1;
  logic   rst_b_q = 1'b1;

  task automatic push_f(input int mode, input bit muted);
    frame_t f;
    f.mode  = mode;
    f.muted = muted;
    sb.push_back(f);
  endtask

  task automatic pop_frame();
    check_val("b_sb_nonempty", int'(sb.size() > 0), 1);
    if (sb.size() > 0) cur = sb.pop_front();
  endtask

  always @(posedge clk) rst_b_q <= rst_b;

  always @(negedge clk) begin : mon_b
    int m, cxe, cye, hb, vb;
    if (rst_b_q) begin
      need_pop = 1'b1;
      t_b = 0;
      k_b = 0;
    end else begin
      if (need_pop) begin
        pop_frame();
        need_pop = 1'b0;
      end
      m   = cur.mode;
      cxe = t_b % bht[m];
      cye = t_b / bht[m];
      hb  = bha[m] + bhf[m];
      vb  = bva[m] + bvf[m];
      check_val("b_cx", int'(b_cx), cxe);
      check_val("b_cy", int'(b_cy), cye);
      check_val("b_hsync", int'(b_hs), (cxe >= hb && cxe < hb + bhs[m]) ? 0 : 1);
      check_val("b_vsync", int'(b_vs), (cye >= vb && cye < vb + bvs[m]) ? 0 : 1);
      check_val("b_de", int'(b_de), (cxe < bha[m] && cye < bva[m] && !cur.muted) ? 1 : 0);
      check_val("b_frame_start", int'(b_fs), (t_b == 0) ? 1 : 0);
      check_val("b_active_mode", int'(b_am), m);
      k_b++;
      t_b++;
      if (t_b == bht[m] * bvt[m]) begin
        t_b = 0;
        pop_frame();
      end
    end
  end

  // Returns at the negedge where u_b presents output cycle n; inputs driven there are sampled on cycle n.
  task automatic goto_k(input int n);
    int guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (k_b != n && guard < 5000);
    check_val("goto_k", k_b, n);
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int fmode[13]  = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int sw_end;

  initial begin
    // ---------------- u_a: reset state, then CEA 480p lines with a pending switch ----------------
    repeat (3) @(negedge clk);
    check_rst("a_rst", int'(a_cx), int'(a_cy), int'(a_hs), int'(a_vs), int'(a_de), int'(a_fs),
              int'(a_am), int'(a_sw));
    rst_a = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      int cxe, cye;
      @(negedge clk);
      cxe = k % 858;
      cye = k / 858;
      check_val("a_cx", int'(a_cx), cxe);
      check_val("a_cy", int'(a_cy), cye);
      check_val("a_hsync", int'(a_hs), (cxe >= 736 && cxe <= 797) ? 0 : 1);
      check_val("a_vsync", int'(a_vs), 1);
      check_val("a_de", int'(a_de), (cxe < 720 && cye < 480) ? 1 : 0);
      check_val("a_frame_start", int'(a_fs), (k == 0) ? 1 : 0);
      check_val("a_active_mode", int'(a_am), 0);
      if (k >= 1002) check_val("a_switching", int'(a_sw), 1);
      if (k == 1000) req_a = 1'b1;
    end

    // ---------------- u_b: frames 0..12 ----------------
    check_rst("b_rst", int'(b_cx), int'(b_cy), int'(b_hs), int'(b_vs), int'(b_de), int'(b_fs),
              int'(b_am), int'(b_sw));
    for (int i = 0; i < 13; i++)
      push_f(fmode[i], ((i >= 2 && i < 2 + MUTE_N) || (i >= 8 && i < 8 + MUTE_N)));
    rst_b = 1'b0;

    // Switch 0->1 requested mid frame 1; lands at cycle 400.
    goto_k(250); req_b = 2'd1;
    goto_k(252); check_val("b_sw_req", int'(b_sw), 1);
    goto_k(398); check_val("b_sw_pend", int'(b_sw), 1);
    sw_end = 400 + MUTE_N * 288;
    goto_k(sw_end - 1); check_val("b_sw_before_end", int'(b_sw), 1);
    goto_k(sw_end); check_val("b_sw_end", int'(b_sw), 0);

    // Request 1->0 then withdraw before the frame ends: frame 5 keeps mode 1.
    goto_k(1300); req_b = 2'd0;
    goto_k(1302); check_val("b_sw_cancel_req", int'(b_sw), 1);
    goto_k(1400); req_b = 2'd1;
    goto_k(1402); check_val("b_sw_cancelled", int'(b_sw), 0);

    // Request sampled on the last pixel of frame 6 while idle: switch at the end of frame 7.
    goto_k(1839); req_b = 2'd0;
    goto_k(1841); check_val("b_sw_bnd_req", int'(b_sw), 1);
    goto_k(2127); check_val("b_sw_bnd_pend", int'(b_sw), 1);
    goto_k(2128 + MUTE_N * 200); check_val("b_sw_bnd_end", int'(b_sw), 0);

    // Pending 0->1 withdrawn on the boundary cycle itself: no switch.
    goto_k(2600); req_b = 2'd1;
    goto_k(2602); check_val("b_sw_bnd_cancel_req", int'(b_sw), 1);
    goto_k(2727); req_b = 2'd0;
    goto_k(2728); check_val("b_sw_bnd_cancelled", int'(b_sw), 0);

    // Out-of-range requests are ignored.
    goto_k(2750); req_b = 2'd2;
    goto_k(2752); check_val("b_sw_oor2", int'(b_sw), 0);
    goto_k(2800); req_b = 2'd3;
    goto_k(2802); check_val("b_sw_oor3", int'(b_sw), 0);
    goto_k(2900); check_val("b_sw_oor_hold", int'(b_sw), 0);
    goto_k(2920); req_b = 2'd0;

    // Reset while pending at cx=5, cy=3 of frame 12.
    goto_k(2950); req_b = 2'd1;
    goto_k(2952); check_val("b_sw_pre_rst", int'(b_sw), 1);
    goto_k(2993);
    rst_b = 1'b1;
    req_b = 2'd0;
    sb.delete();
    push_f(0, 1'b0);
    push_f(0, 1'b0);
    @(negedge clk);
    check_rst("b_pend_rst", int'(b_cx), int'(b_cy), int'(b_hs), int'(b_vs), int'(b_de), int'(b_fs),
              int'(b_am), int'(b_sw));
    rst_b = 1'b0;
    goto_k(210); check_val("b_sw_after_rst", int'(b_sw), 0);
    goto_k(390);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hdmi_timing_selector.md
Name: hdmi_timing_selector

Overview:
Parametrised successor to the fixed NTSC/PAL selection path. One shared raster counter replaces per-mode counters and an output mux.
- Generates cx/cy, hsync, vsync and data-enable for up to three built-in CEA timings.
- Mode changes take effect only at a frame boundary, with optional video mute afterwards.
- Sits between the VDP pixel pipeline and the TMDS encoder/serializer. The pixel clock itself is selected externally.

Parameters:
NUM_MODES, 2, number of usable table entries (1..3); entries above NUM_MODES-1 are unreachable.
DEFAULT_MODE, 0, mode index loaded at reset; must be < NUM_MODES.
MUTE_FRAMES, 2, frames with de forced low after a switch (1..15); used only with TIMING_MUTE_EN.
MW, $clog2(NUM_MODES) min 1, width of mode index ports.

Ports:
clk_pixel  in  1  pixel clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
mode_req  in  MW  requested mode index; level, sampled every cycle.
cx  out  11  horizontal position, 0..H_TOTAL-1.
cy  out  10  vertical position, 0..V_TOTAL-1.
hsync  out  1  horizontal sync, active-low.
vsync  out  1  vertical sync, active-low.
de  out  1  active video (cx<H_ACTIVE && cy<V_ACTIVE, and not muted).
frame_start  out  1  one-cycle pulse when cx=0,cy=0.
active_mode  out  MW  mode whose timing currently drives the counters.
switching  out  1  high from request latch until mute completes.

Behaviour:
- Timing table, as H_TOTAL/H_ACTIVE/HFP/HSW; V_TOTAL/V_ACTIVE/VFP/VSW:
  - 0 = VIC2 720x480p: 858/720/16/62; 525/480/9/6.
  - 1 = VIC17 720x576p: 864/720/12/64; 625/576/5/5.
  - 2 = VIC1 640x480p: 800/640/16/96; 525/480/10/2.
- Sync windows:
  - hsync low for H_ACTIVE+HFP <= cx < H_ACTIVE+HFP+HSW.
  - vsync low for V_ACTIVE+VFP <= cy < V_ACTIVE+VFP+VSW, evaluated on cy only (progressive, no half-line offset).
- Counters:
  - cx increments each cycle and wraps to 0 at H_TOTAL-1.
  - cy increments on the cx wrap and wraps to 0 at V_TOTAL-1.
- All outputs are registered and decoded from the counter values of the same cycle, so hsync/vsync/de/frame_start align exactly with the cx/cy outputs. Latency from counter to output is 0 relative to cx/cy.
- Reset values: cx=0, cy=0, hsync=1, vsync=1, de=0, frame_start=0, active_mode=DEFAULT_MODE, switching=0, pending=none, mute counter=0. The first cycle after reset release presents cx=0, cy=0, frame_start=1.
- Mode-change FSM, states IDLE, PENDING, MUTE:
  - IDLE: if mode_req != active_mode and mode_req < NUM_MODES, latch target and go to PENDING; switching=1. Out-of-range mode_req is ignored, and the FSM stays IDLE.
  - PENDING: at the last pixel of the frame (cx=H_TOTAL-1, cy=V_TOTAL-1 of the current mode), set active_mode=target and wrap counters to 0,0. The next frame uses the new table.
  - After that wrap: go to MUTE if the macro is defined, else IDLE with switching=0.
  - While in PENDING, mode_req is re-sampled each cycle. A new valid value overwrites the target. If mode_req returns to active_mode, cancel back to IDLE with switching=0 and no timing change.
  - A request change on the boundary cycle itself: the value sampled on that cycle wins.
  - MUTE: de forced 0; decrement on each frame_start; return to IDLE with switching=0 when the count hits 0. A new request during MUTE is held until IDLE, then handled normally.
- The counters never jump mid-frame, so no truncated line or frame is emitted.
- Reset mid-switch abandons the switch and restores DEFAULT_MODE immediately.

Optional Feature:
Macro TIMING_MUTE_EN.
- Defined: the MUTE state is present. de is held low for MUTE_FRAMES full frames after each completed switch while syncs run normally.
- Undefined: no MUTE state and no mute counter. de resumes on the first frame of the new mode, and switching drops on the wrap cycle.

Test Plan:
- Reset, mode_req=0, run 858*525 cycles: frame_start period 450450; hsync low at cx 736..797; vsync low at cy 489..494; de high 720 cycles/line on lines 0..479.
- Reset, mode_req=1 asserted at cycle 1000: active_mode stays 0 until cycle 450449; the next cycle has cx=0, cy=0, active_mode=1; the next frame period is 540000 and hsync low at cx 732..795.
- TIMING_MUTE_EN, MUTE_FRAMES=2, switch 0->1: de=0 for 2 full 576p frames after the switch; switching falls on the 2nd following frame_start; de high on line 0 of the 3rd frame.
- mode_req 0->1 then back to 0 before the frame end: switching pulses high then low, with no change to active_mode or the frame period.
- NUM_MODES=2, mode_req=2 (MW=2 override) or out of range: ignored, switching stays 0.
- Assert reset during PENDING at cx=100, cy=200: next cycle cx=0, cy=0, active_mode=DEFAULT_MODE, switching=0, hsync=vsync=1, de=0.
